max10_button_bank: RTL
======================

MAX10_BUTTON_BANK -- requirements
Module: max10_button_bank

Interface
REQ-001 SHALL provide parameter CLK_SHIFT, default 1: a slot tick occurs every 2^CLK_SHIFT clk cycles (CLK_SHIFT>=1).
REQ-002 SHALL provide parameter PERIOD, default 80: a frame is 2*PERIOD slots; legal range 65..128.
REQ-003 SHALL provide parameter NUM_BUTTONS, default 4: channel count, 1..16.
REQ-004 SHALL provide parameter DEBOUNCE, default 2: frames of agreement needed to change a button state, >=2.
REQ-005 SHALL provide parameter FIRST_SLOT, default 8'h61: sample slot of channel 0.
REQ-006 SHALL provide parameter SLOT_STEP, default 2: slot spacing between channels; FIRST_SLOT+(NUM_BUTTONS-1)*SLOT_STEP SHALL be <128, else elaboration error.
REQ-007 SHALL provide parameter LED_FIRST_SLOT, default 8'h21: rx drive slot of LED 0; uses the same spacing and bound as REQ-006.
REQ-008 clk  in  1  system clock; the only clock.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 rx  out  1  serial data to MAX10 (LED bits).
REQ-011 tx  in  1  serial data from MAX10, active-low button bits.
REQ-012 sync  out  1  frame/slot clock to MAX10.
REQ-013 led  in  NUM_BUTTONS  LED levels to transmit.
REQ-014 buttons  out  NUM_BUTTONS  debounced button state, 1 = pressed.
REQ-015 pressed  out  NUM_BUTTONS  one-clk pulse on 0->1 of buttons[i].
REQ-016 released  out  NUM_BUTTONS  one-clk pulse on 1->0 of buttons[i].
REQ-017 link_err  out  1  1 while the last completed frame was a stuck frame.

Function
REQ-018 Prescaler SHALL count clk; a tick is the cycle where its low CLK_SHIFT bits are all ones; all actions below occur only on ticks.
REQ-019 Slot counter cnt (8 bits) SHALL increment per tick and wrap from 2*PERIOD-1 to 0.
REQ-020 sync SHALL be registered at each tick as cnt[0] AND NOT cnt[7] (toggling in slots 0..127, low in 128..2*PERIOD-1).
REQ-021 On the tick where cnt == FIRST_SLOT+i*SLOT_STEP, raw[i] SHALL capture NOT tx.
REQ-022 On every tick with cnt odd, the block SHALL record whether tx was seen 0 and whether tx was seen 1 during the frame.
REQ-023 On the tick where cnt == LED_FIRST_SLOT+i*SLOT_STEP, rx SHALL be registered to led[i]; on all other ticks rx SHALL be registered to 0.
REQ-024 On the tick where cnt == 128 (frame end), each channel's DEBOUNCE-bit shift register SHALL shift in one bit: raw[i] if both tx values were seen, else 0 (stuck frame); the seen-flags then clear for the next frame.
REQ-025 link_err SHALL be set at frame end to 1 for a stuck frame and 0 otherwise.
REQ-026 buttons[i] SHALL become 1 when its shift register is all ones, 0 when all zeros, and hold otherwise (hysteresis).
REQ-027 pressed[i]/released[i] SHALL assert for exactly the one clk cycle following the buttons[i] change; never both at once.
REQ-028 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each pulse.
REQ-029 Channel output latency from first valid sample to buttons change SHALL be DEBOUNCE frame ends.

Reset
REQ-030 reset SHALL asynchronously clear the prescaler, cnt, raw, seen-flags, shift registers, buttons, pressed, released, link_err, rx and sync to 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release, the first frame starts at cnt=0 and no pulse fires for the aborted frame.

Verification
REQ-032 Default params, MAX10 model drives channel 1 low (pressed) every frame with toggling odd slots -> buttons=4'b0010 after 2nd frame end, pressed[1] one clk, no other pulses.
REQ-033 Channel 1 pressed for a single frame only (DEBOUNCE=2) -> buttons stays 0, no pulses.
REQ-034 Held button then tx stuck at 1 for 2 frames -> link_err=1 after 1st stuck frame end, buttons[1] 1->0 after 2nd, released[1] pulse.
REQ-035 led=4'b1010 -> rx high exactly on ticks at slots 0x23 and 0x27 each frame, low elsewhere; sync period 2 slots, low for slots 128..159.
REQ-036 reset pulsed at cnt=0x70 while buttons=4'b0011 -> all outputs 0 asynchronously; after release cnt restarts at 0, buttons reassert after 2 frame ends.

Source files
------------

// File: rtl/max10_button_bank.sv
// Serial button/LED bank for the MAX10 companion chip: time-slotted sync/rx/tx
// framing, per-channel debounce with hysteresis, and edge pulses.
module max10_button_bank #(
    parameter int         CLK_SHIFT      = 1,
    parameter int         PERIOD         = 80,
    parameter int         NUM_BUTTONS    = 4,
    parameter int         DEBOUNCE       = 2,
    parameter logic [7:0] FIRST_SLOT     = 8'h61,
    parameter int         SLOT_STEP      = 2,
    parameter logic [7:0] LED_FIRST_SLOT = 8'h21
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   rx,
    input  logic                   tx,
    output logic                   sync,
    input  logic [NUM_BUTTONS-1:0] led,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released,
    output logic                   link_err
);

    localparam logic [7:0] LAST_SLOT = 8'(2 * PERIOD - 1);
    localparam logic [7:0] END_SLOT  = 8'd128;

    if (CLK_SHIFT < 1 || PERIOD < 65 || PERIOD > 128 ||
        NUM_BUTTONS < 1 || NUM_BUTTONS > 16 || DEBOUNCE < 2 ||
        int'(FIRST_SLOT) + (NUM_BUTTONS - 1) * SLOT_STEP >= 128 ||
        int'(LED_FIRST_SLOT) + (NUM_BUTTONS - 1) * SLOT_STEP >= 128) begin : g_param_err
        $error("max10_button_bank: illegal parameter combination");
    end

    logic [CLK_SHIFT-1:0]   presc_q, presc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   sync_q, sync_d;
    logic                   rx_q, rx_d;
    logic                   seen0_q, seen0_d;
    logic                   seen1_q, seen1_d;
    logic                   link_err_q, link_err_d;
    logic                   tick;
    logic                   frame_end;
    logic                   frame_ok;
    logic [NUM_BUTTONS-1:0] led_hit;

    assign tick      = &presc_q;
    assign frame_end = tick && (cnt_q == END_SLOT);
    assign frame_ok  = seen0_q & seen1_q;

    always_comb begin
        presc_d    = presc_q + 1'b1;
        cnt_d      = cnt_q;
        sync_d     = sync_q;
        rx_d       = rx_q;
        seen0_d    = seen0_q;
        seen1_d    = seen1_q;
        link_err_d = link_err_q;
        if (tick) begin
            cnt_d  = (cnt_q == LAST_SLOT) ? 8'd0 : cnt_q + 8'd1;
            sync_d = cnt_q[0] & ~cnt_q[7];
            rx_d   = |led_hit;
            // Frame end is an even slot, so it never overlaps the odd-slot line monitor.
            if (frame_end) begin
                seen0_d    = 1'b0;
                seen1_d    = 1'b0;
                link_err_d = ~frame_ok;
            end else if (cnt_q[0]) begin
                seen0_d = seen0_q | ~tx;
                seen1_d = seen1_q | tx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            sync_q     <= 1'b0;
            rx_q       <= 1'b0;
            seen0_q    <= 1'b0;
            seen1_q    <= 1'b0;
            link_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            rx_q       <= rx_d;
            seen0_q    <= seen0_d;
            seen1_q    <= seen1_d;
            link_err_q <= link_err_d;
        end
    end

    assign rx       = rx_q;
    assign sync     = sync_q;
    assign link_err = link_err_q;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
        localparam logic [7:0] BTN_SLOT = 8'(int'(FIRST_SLOT) + gi * SLOT_STEP);
        localparam logic [7:0] LED_SLOT = 8'(int'(LED_FIRST_SLOT) + gi * SLOT_STEP);

        logic                raw_q, raw_d;
        logic [DEBOUNCE-1:0] shift_q, shift_d;
        logic                btn_q, btn_d;
        logic                pressed_q, released_q;

        assign led_hit[gi] = (cnt_q == LED_SLOT) & led[gi];

        always_comb begin
            raw_d   = raw_q;
            shift_d = shift_q;
            btn_d   = btn_q;
            if (tick && cnt_q == BTN_SLOT) begin
                raw_d = ~tx;
            end
            // A stuck frame counts as "released" so a dead link eventually drops the button.
            if (frame_end) begin
                shift_d = {shift_q[DEBOUNCE-2:0], raw_q & frame_ok};
            end
            if (&shift_q) begin
                btn_d = 1'b1;
            end else if (~|shift_q) begin
                btn_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                raw_q      <= 1'b0;
                shift_q    <= '0;
                btn_q      <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                raw_q      <= raw_d;
                shift_q    <= shift_d;
                btn_q      <= btn_d;
                pressed_q  <= btn_d & ~btn_q;
                released_q <= ~btn_d & btn_q;
            end
        end

        assign buttons[gi]  = btn_q;
        assign pressed[gi]  = pressed_q;
        assign released[gi] = released_q;
    end

endmodule
